bus_arbiter: RTL and testbench
==============================

// Module: bus_arbiter
// PURPOSE
//   Shares the single external memory bus between instruction fetch (rom_*) and the MEM stage (ram_*).
//   Serves at most one bus transaction at a time, data first, and latches the returned read data.
//   Raises stall_all into the pipeline controller until every access requested this round has completed.
//   Adds a watchdog so that a slave which never answers cannot hang the core.
// PARAMETERS
//   ADDR_WIDTH   32   address width, all ports
//   DATA_WIDTH   32   data width; byte-enable width is DATA_WIDTH/8
//   TIMEOUT      255  max wait cycles per transaction for bus_ready; 0 disables the watchdog
// PORTS
//   clk           in   1     clock, all state on rising edge
//   rst           in   1     synchronous reset, active-high
//   rom_en        in   1     fetch read request (level, held while stall_all)
//   rom_addr      in   AW    fetch address
//   rom_rdata     out  DW    latched fetch data
//   ram_en        in   1     data access request (level, held while stall_all)
//   ram_write_en  in   DW/8  byte write enables; 0 = read
//   ram_addr      in   AW    data address
//   ram_wdata     in   DW    store data
//   ram_rdata     out  DW    latched load data
//   bus_en        out  1     transaction active on bus
//   bus_write_en  out  DW/8  byte enables driven to slave
//   bus_addr      out  AW    bus address
//   bus_wdata     out  DW    bus store data
//   bus_rdata     in   DW    slave read data, valid with bus_ready
//   bus_ready     in   1     slave completes current transaction
//   stall_all     out  1     to pipeline controller: freeze all stages
//   bus_timeout   out  1     one-cycle pulse when watchdog expires
// BEHAVIOUR
//   Reset values: state=IDLE; bus_en, bus_write_en, bus_addr, bus_wdata, rom_rdata, ram_rdata, bus_timeout, wait counter = 0.
//   FSM states: IDLE, DATA, INST, RELEASE.
//   IDLE:
//     - ram_en -> DATA; else rom_en -> INST; else stay.
//     - stall_all = rom_en|ram_en (combinational).
//   DATA:
//     - bus_* = ram_*; bus_en=1; stall_all=1.
//     - On bus_ready: ram_rdata <= bus_rdata (only if ram_write_en==0); next INST if rom_en else RELEASE.
//   INST:
//     - bus_* = rom_addr with write_en=0; bus_en=1; stall_all=1.
//     - On bus_ready: rom_rdata <= bus_rdata; next RELEASE.
//   RELEASE:
//     - stall_all=0 and bus_en=0 for exactly one cycle; the pipeline advances and consumes the latched data.
//     - Next state IDLE.
//   Latency:
//     - Bus signals are driven combinationally from state and master inputs.
//     - Single access, slave ready after k cycles: stall for 1+k cycles, then RELEASE.
//     - rom+ram in the same round: 1+k1+k2 stall cycles, data access first.
//   Watchdog:
//     - Counter clears on entering DATA/INST and counts each cycle without bus_ready.
//     - When the counter equals TIMEOUT, treat the transaction as completed with rdata=0.
//     - bus_timeout pulses for one cycle and the FSM follows the normal bus_ready path.
//   bus_ready in IDLE or RELEASE is ignored.
//   Masters dropping rom_en/ram_en mid-access: the current transaction still completes; requests are re-sampled only at IDLE and at DATA exit.
//   rst mid-transaction: state returns to IDLE the next edge, bus_en drops, latched data clears; no partial write retry.
// STRUCTURE
//   Shared header (alongside bus.v): state encodings ARB_IDLE/ARB_DATA/ARB_INST/ARB_RELEASE (2 bits).
//   One sub-module bus_watchdog: counter, clear/enable/ready inputs, expire pulse output.
//   stall_all ORs into the pipeline controller's stall_all; no other pipeline changes.
// TESTING
//   1 Fetch only: rom_en=1, rom_addr=0xBFC00000, bus_ready after 2 cycles with rdata=0x24020001
//     -> stall_all high for 3 cycles, RELEASE, rom_rdata=0x24020001.
//   2 Load+fetch: ram_en=1, ram_addr=0x80000010, rom_en=1; ready 1 cycle each
//     -> bus_addr 0x80000010 then the rom address; ram_rdata and rom_rdata latched; 3 stall cycles.
//   3 Store: ram_write_en=4'b0011, ram_wdata=0xA5A5
//     -> bus_write_en=0011 during DATA; ram_rdata unchanged; fetch follows.
//   4 Timeout, TIMEOUT=4, slave silent
//     -> bus_timeout pulses once after 4 wait cycles; rom_rdata=0; RELEASE reached.
//   5 rst asserted in DATA
//     -> next cycle bus_en=0, stall_all follows IDLE rule, outputs zero.
//   6 bus_ready asserted while IDLE
//     -> no state change; latched data unchanged.

Source files
------------

// File: rtl/bus_arbiter_pkg.sv
// Shared definitions for the memory bus arbiter: FSM state encoding and a small decode helper.
package bus_arbiter_pkg;

  // 2-bit arbiter state encoding
  typedef enum logic [1:0] {
    ARB_IDLE    = 2'd0,
    ARB_DATA    = 2'd1,
    ARB_INST    = 2'd2,
    ARB_RELEASE = 2'd3
  } arb_state_e;

  // True while a transaction is being driven onto the external bus
  function automatic logic arb_on_bus(arb_state_e state);
    return (state == ARB_DATA) || (state == ARB_INST);
  endfunction

endpackage

// File: rtl/bus_arbiter_if.sv
// Bundle of the fetch port, data port, external bus and pipeline stall/timeout signals.
// The master modport is the arbiter's view (it masters the external bus); the slave modport is
// the environment's view (pipeline masters, memory slave and pipeline controller).
interface bus_arbiter_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
);

  localparam int unsigned BeWidth = DATA_WIDTH / 8;

  // Instruction fetch port
  logic                  rom_en;
  logic [ADDR_WIDTH-1:0] rom_addr;
  logic [DATA_WIDTH-1:0] rom_rdata;

  // MEM stage data port
  logic                  ram_en;
  logic [BeWidth-1:0]    ram_write_en;
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic [DATA_WIDTH-1:0] ram_wdata;
  logic [DATA_WIDTH-1:0] ram_rdata;

  // External memory bus
  logic                  bus_en;
  logic [BeWidth-1:0]    bus_write_en;
  logic [ADDR_WIDTH-1:0] bus_addr;
  logic [DATA_WIDTH-1:0] bus_wdata;
  logic [DATA_WIDTH-1:0] bus_rdata;
  logic                  bus_ready;

  // Pipeline controller
  logic                  stall_all;
  logic                  bus_timeout;

  modport master (
    input  rom_en, rom_addr,
    input  ram_en, ram_write_en, ram_addr, ram_wdata,
    input  bus_rdata, bus_ready,
    output rom_rdata, ram_rdata,
    output bus_en, bus_write_en, bus_addr, bus_wdata,
    output stall_all, bus_timeout
  );

  modport slave (
    output rom_en, rom_addr,
    output ram_en, ram_write_en, ram_addr, ram_wdata,
    output bus_rdata, bus_ready,
    input  rom_rdata, ram_rdata,
    input  bus_en, bus_write_en, bus_addr, bus_wdata,
    input  stall_all, bus_timeout
  );

endinterface

// File: rtl/bus_watchdog.sv
// Per-transaction wait counter. Counts cycles without ready while enabled and flags expiry when
// the count reaches TIMEOUT. TIMEOUT of 0 disables expiry entirely.
module bus_watchdog #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  input  logic ready,
  output logic expire
);

  localparam int unsigned   CntWidth = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CntWidth-1:0] Limit = CntWidth'(TIMEOUT);

  logic [CntWidth-1:0] cnt_q;

  // Wait counter: saturates at the limit so it can never wrap past it
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt_q <= '0;
    end else if (enable && !ready && (cnt_q != Limit)) begin
      cnt_q <= cnt_q + CntWidth'(1);
    end
  end

  // Expiry is flagged in the same cycle the count hits the limit so the FSM can finish there
  always_comb begin
    expire = (TIMEOUT != 0) && enable && !ready && (cnt_q == Limit);
  end

endmodule

// File: rtl/bus_arbiter.sv
// Shares the single external memory bus between instruction fetch and the MEM stage.
// One transaction at a time, data access first, read data latched for the pipeline.
// stall_all freezes the pipeline until every access requested this round has completed,
// followed by one RELEASE cycle in which the pipeline consumes the latched data.
module bus_arbiter
  import bus_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned TIMEOUT    = 255
) (
  input  logic          clk,
  input  logic          rst,
  bus_arbiter_if.master arb
);

  localparam int unsigned BeWidth = DATA_WIDTH / 8;

  arb_state_e state_q, state_d;

  logic [DATA_WIDTH-1:0] rom_rdata_q, rom_rdata_d;
  logic [DATA_WIDTH-1:0] ram_rdata_q, ram_rdata_d;

  logic                  drv_en;
  logic [BeWidth-1:0]    drv_write_en;
  logic [ADDR_WIDTH-1:0] drv_addr;
  logic [DATA_WIDTH-1:0] drv_wdata;
  logic                  stall;

  logic                  on_bus;
  logic                  wd_clear;
  logic                  wd_expire;
  logic                  done;
  logic [DATA_WIDTH-1:0] resp_data;

  // Transaction completion: slave answered, or the watchdog gave up on it
  always_comb begin
    on_bus    = arb_on_bus(state_q);
    done      = on_bus && (arb.bus_ready || wd_expire);
    // A timed-out transaction returns zero rather than whatever sits on the bus
    resp_data = arb.bus_ready ? arb.bus_rdata : '0;
    // Clearing on completion means the counter starts from zero on entering DATA or INST
    wd_clear  = !on_bus || done;
  end

  bus_watchdog #(
    .TIMEOUT(TIMEOUT)
  ) u_watchdog (
    .clk   (clk),
    .rst   (rst),
    .clear (wd_clear),
    .enable(on_bus),
    .ready (arb.bus_ready),
    .expire(wd_expire)
  );

  // Next-state, latched read data and combinational bus/stall outputs
  always_comb begin
    state_d      = state_q;
    rom_rdata_d  = rom_rdata_q;
    ram_rdata_d  = ram_rdata_q;
    drv_en       = 1'b0;
    drv_write_en = '0;
    drv_addr     = '0;
    drv_wdata    = '0;
    stall        = 1'b0;

    case (state_q)
      ARB_IDLE: begin
        stall = arb.rom_en || arb.ram_en;
        if (arb.ram_en) begin
          state_d = ARB_DATA;
        end else if (arb.rom_en) begin
          state_d = ARB_INST;
        end
      end

      ARB_DATA: begin
        drv_en       = 1'b1;
        drv_write_en = arb.ram_write_en;
        drv_addr     = arb.ram_addr;
        drv_wdata    = arb.ram_wdata;
        stall        = 1'b1;
        if (done) begin
          // Stores leave the previously loaded data untouched
          if (arb.ram_write_en == '0) begin
            ram_rdata_d = resp_data;
          end
          // Fetch request is re-sampled here so a dropped fetch is not issued
          state_d = arb.rom_en ? ARB_INST : ARB_RELEASE;
        end
      end

      ARB_INST: begin
        drv_en   = 1'b1;
        drv_addr = arb.rom_addr;
        stall    = 1'b1;
        if (done) begin
          rom_rdata_d = resp_data;
          state_d     = ARB_RELEASE;
        end
      end

      ARB_RELEASE: begin
        // Bus idle and pipeline free for exactly this cycle
        state_d = ARB_IDLE;
      end

      default: begin
        state_d = ARB_IDLE;
      end
    endcase
  end

  // State and latched read data registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ARB_IDLE;
      rom_rdata_q <= '0;
      ram_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      rom_rdata_q <= rom_rdata_d;
      ram_rdata_q <= ram_rdata_d;
    end
  end

  // Drive interface outputs
  always_comb begin
    arb.bus_en       = drv_en;
    arb.bus_write_en = drv_write_en;
    arb.bus_addr     = drv_addr;
    arb.bus_wdata    = drv_wdata;
    arb.stall_all    = stall;
    arb.bus_timeout  = wd_expire;
    arb.rom_rdata    = rom_rdata_q;
    arb.ram_rdata    = ram_rdata_q;
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// Scoreboard bench for bus_arbiter: stimulus pushes expected bus transactions and expected
// end-of-round results into queues; a monitor pops and compares them as the DUT presents them.
module tb_bus_arbiter;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  we;
    logic [31:0] wdata;
    logic        tmo;
  } txn_t;

  typedef struct {
    logic [31:0] rom;
    logic [31:0] ram;
    int          stalls;
  } rel_t;

  typedef struct {
    int          lat;   // ready in this many bus cycles; 0 = silent slave
    logic [31:0] data;
  } slv_t;

  logic clk;
  logic rst;

  bus_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) arb ();

  bus_arbiter #(
    .ADDR_WIDTH(32),
    .DATA_WIDTH(32),
    .TIMEOUT   (4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .arb(arb)
  );

  txn_t txn_q[$];
  rel_t rel_q[$];
  slv_t slv_q[$];

  int n_cmp = 0;
  int n_bad = 0;
  int n_tmo = 0;

  logic        ready_force = 1'b0;
  logic [31:0] force_data  = 32'h1234_5678;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Memory slave: answers each transaction after its scheduled latency
  slv_t cur;
  int   wcnt = 0;
  bit   busy = 0;
  logic slv_ready;
  always @(posedge clk) begin
    #2;
    slv_ready = 1'b0;
    if (rst || !arb.bus_en) begin
      busy = 0;
    end else begin
      if (!busy) begin
        busy = 1;
        wcnt = 0;
        if (slv_q.size() > 0) cur = slv_q.pop_front();
        else cur = '{lat: 0, data: 32'h0};
      end
      wcnt++;
      slv_ready = (cur.lat != 0) && (wcnt == cur.lat);
    end
    arb.bus_ready = slv_ready || ready_force;
    arb.bus_rdata = slv_ready ? cur.data : (ready_force ? force_data : 32'hDEAD_BEEF);
    @(negedge clk);
    if (arb.bus_en && (arb.bus_ready || arb.bus_timeout)) busy = 0;
  end

  // Monitor: checks completed bus transactions and the data visible at the end of each round
  int run = 0;
  always @(negedge clk) begin
    if (rst) begin
      run = 0;
    end else begin
      if (arb.bus_timeout) n_tmo++;
      if (arb.bus_en && (arb.bus_ready || arb.bus_timeout)) begin
        chk("txn expected", txn_q.size() > 0, 1);
        if (txn_q.size() > 0) begin
          txn_t t;
          t = txn_q.pop_front();
          chk("txn addr", arb.bus_addr, t.addr);
          chk("txn write_en", arb.bus_write_en, t.we);
          if (t.we != 0) chk("txn wdata", arb.bus_wdata, t.wdata);
          chk("txn timeout", arb.bus_timeout, t.tmo);
        end
      end
      if (arb.stall_all) begin
        run++;
      end else if (run > 0) begin
        chk("release expected", rel_q.size() > 0, 1);
        if (rel_q.size() > 0) begin
          rel_t r;
          r = rel_q.pop_front();
          chk("release rom_rdata", arb.rom_rdata, r.rom);
          chk("release ram_rdata", arb.ram_rdata, r.ram);
          chk("release stall cycles", run, r.stalls);
          chk("release bus_en", arb.bus_en, 0);
        end
        run = 0;
      end
    end
  end

  // Waits (bounded) for the RELEASE cycle, then drops requests and returns to IDLE
  task automatic finish_round(input string name);
    int i;
    for (i = 0; i < 50; i++) begin
      step();
      if (!arb.stall_all) break;
    end
    chk({name, " reached release"}, i < 50, 1);
    arb.rom_en       = 1'b0;
    arb.ram_en       = 1'b0;
    arb.ram_write_en = 4'b0;
    step();
  endtask

  initial begin
    rst              = 1'b1;
    arb.rom_en       = 1'b0;
    arb.rom_addr     = 32'h0;
    arb.ram_en       = 1'b0;
    arb.ram_write_en = 4'b0;
    arb.ram_addr     = 32'h0;
    arb.ram_wdata    = 32'h0;
    repeat (2) step();

    // Reset state
    chk("reset bus_en", arb.bus_en, 0);
    chk("reset bus_addr", arb.bus_addr, 0);
    chk("reset bus_write_en", arb.bus_write_en, 0);
    chk("reset stall_all", arb.stall_all, 0);
    chk("reset rom_rdata", arb.rom_rdata, 0);
    chk("reset ram_rdata", arb.ram_rdata, 0);
    chk("reset bus_timeout", arb.bus_timeout, 0);
    rst = 1'b0;
    step();

    // Fetch only, slave ready in the second bus cycle
    slv_q.push_back('{lat: 2, data: 32'h2402_0001});
    txn_q.push_back('{addr: 32'hBFC0_0000, we: 4'b0, wdata: 32'h0, tmo: 1'b0});
    rel_q.push_back('{rom: 32'h2402_0001, ram: 32'h0, stalls: 3});
    arb.rom_addr = 32'hBFC0_0000;
    arb.rom_en   = 1'b1;
    finish_round("fetch");

    // Silent slave on a fetch: watchdog completes it with zero data
    slv_q.push_back('{lat: 0, data: 32'h0});
    txn_q.push_back('{addr: 32'hBFC0_0004, we: 4'b0, wdata: 32'h0, tmo: 1'b1});
    rel_q.push_back('{rom: 32'h0, ram: 32'h0, stalls: 6});
    arb.rom_addr = 32'hBFC0_0004;
    arb.rom_en   = 1'b1;
    finish_round("timeout");

    // Load plus fetch in the same round, data first
    slv_q.push_back('{lat: 1, data: 32'h0000_1234});
    slv_q.push_back('{lat: 1, data: 32'h2403_0002});
    txn_q.push_back('{addr: 32'h8000_0010, we: 4'b0, wdata: 32'h0, tmo: 1'b0});
    txn_q.push_back('{addr: 32'hBFC0_0008, we: 4'b0, wdata: 32'h0, tmo: 1'b0});
    rel_q.push_back('{rom: 32'h2403_0002, ram: 32'h0000_1234, stalls: 3});
    arb.ram_addr = 32'h8000_0010;
    arb.ram_en   = 1'b1;
    arb.rom_addr = 32'hBFC0_0008;
    arb.rom_en   = 1'b1;
    finish_round("load+fetch");

    // Store plus fetch: byte enables on the bus, load data left alone
    slv_q.push_back('{lat: 1, data: 32'hFFFF_FFFF});
    slv_q.push_back('{lat: 1, data: 32'h2404_0003});
    txn_q.push_back('{addr: 32'h8000_0014, we: 4'b0011, wdata: 32'h0000_A5A5, tmo: 1'b0});
    txn_q.push_back('{addr: 32'hBFC0_000C, we: 4'b0, wdata: 32'h0, tmo: 1'b0});
    rel_q.push_back('{rom: 32'h2404_0003, ram: 32'h0000_1234, stalls: 3});
    arb.ram_addr     = 32'h8000_0014;
    arb.ram_write_en = 4'b0011;
    arb.ram_wdata    = 32'h0000_A5A5;
    arb.ram_en       = 1'b1;
    arb.rom_addr     = 32'hBFC0_000C;
    arb.rom_en       = 1'b1;
    finish_round("store+fetch");

    // bus_ready while IDLE is ignored
    ready_force = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      chk("idle-ready bus_en", arb.bus_en, 0);
      chk("idle-ready stall_all", arb.stall_all, 0);
      chk("idle-ready rom_rdata", arb.rom_rdata, 32'h2404_0003);
      chk("idle-ready ram_rdata", arb.ram_rdata, 32'h0000_1234);
    end
    ready_force = 1'b0;
    step();

    // Arbiter still in IDLE: a fresh fetch takes the normal 1+k stall cycles
    slv_q.push_back('{lat: 1, data: 32'h2405_0004});
    txn_q.push_back('{addr: 32'hBFC0_0010, we: 4'b0, wdata: 32'h0, tmo: 1'b0});
    rel_q.push_back('{rom: 32'h2405_0004, ram: 32'h0000_1234, stalls: 2});
    arb.rom_addr = 32'hBFC0_0010;
    arb.rom_en   = 1'b1;
    finish_round("post-idle fetch");

    // Reset while in DATA with a silent slave
    slv_q.push_back('{lat: 0, data: 32'h0});
    arb.ram_addr = 32'h8000_0020;
    arb.ram_en   = 1'b1;
    step();
    chk("pre-reset bus_en", arb.bus_en, 1);
    chk("pre-reset bus_addr", arb.bus_addr, 32'h8000_0020);
    #2;
    rst = 1'b1;
    step();
    chk("post-reset bus_en", arb.bus_en, 0);
    chk("post-reset stall_all", arb.stall_all, 1);
    chk("post-reset bus_addr", arb.bus_addr, 0);
    chk("post-reset rom_rdata", arb.rom_rdata, 0);
    chk("post-reset ram_rdata", arb.ram_rdata, 0);
    chk("post-reset bus_timeout", arb.bus_timeout, 0);
    rst        = 1'b0;
    arb.ram_en = 1'b0;
    step();
    chk("after reset stall_all", arb.stall_all, 0);
    chk("after reset bus_en", arb.bus_en, 0);
    repeat (2) step();

    chk("timeout pulse count", n_tmo, 1);
    chk("txn queue drained", txn_q.size(), 0);
    chk("release queue drained", rel_q.size(), 0);
    chk("slave queue drained", slv_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global time limit reached");
    $fatal(1, "time limit");
  end

endmodule
